// File: rtl/cmd_bridge_pkg.sv
// cmd_bridge_pkg: command ids, status codes,
// FSM encodings and header sizing helper.
package cmd_bridge_pkg;

    typedef enum logic [3:0] {
        CMD_RESET     = 4'd0,
        CMD_READ      = 4'd1,
        CMD_WRITE     = 4'd2,
        CMD_REG_READ  = 4'd3,
        CMD_REG_WRITE = 4'd4
    } cmd_id_e;

    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_BAD_ID  = 8'hEE;
    localparam logic [7:0] STS_BAD_REG = 8'hEF;

    typedef logic [3:0] state_t;

    localparam state_t ST_HDR      = 4'd0;
    localparam state_t ST_DECODE   = 4'd1;
    localparam state_t ST_RESET    = 4'd2;
    localparam state_t ST_RD_ISSUE = 4'd3;
    localparam state_t ST_RD_DATA  = 4'd4;
    localparam state_t ST_WR_DATA  = 4'd5;
    localparam state_t ST_RESP     = 4'd6;

    function automatic int hdr_bytes(input int addr_w, input int len_w);
        return (4 + addr_w + len_w + 7) / 8;
    endfunction

endpackage

// File: rtl/cmd_bridge_if.sv
// cmd_bridge_if: host byte streams plus the
// byte-wide memory bus of the command bridge.
interface cmd_bridge_if #(
    parameter int ADDR_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cmd_bridge_hdr.sv
// cmd_bridge_hdr: collects little-endian header
// bytes and presents the decoded fields.
module cmd_bridge_hdr
    import cmd_bridge_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 14
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_take,
    input  logic [7:0]        i_data,
    output logic              o_last,
    output logic              o_hdr_valid,
    output logic [3:0]        o_id,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LEN_W-1:0]  o_len
);
    localparam int NB = hdr_bytes(ADDR_W, LEN_W);
    localparam int HW = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hdr_q;

    assign o_last = i_take && (cnt_q == CW'(NB - 1));
    assign o_len  = hdr_q[LEN_W-1:0];
    assign o_addr = hdr_q[LEN_W +: ADDR_W];
    assign o_id   = hdr_q[LEN_W+ADDR_W +: 4];

    // Store each accepted byte at its slot; pulse valid after the last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            hdr_q       <= '0;
            o_hdr_valid <= 1'b0;
        end else begin
            o_hdr_valid <= o_last;
            if (i_take) begin
                for (int b = 0; b < NB; b++) begin
                    if (cnt_q == CW'(b)) hdr_q[b*8 +: 8] <= i_data;
                end
                cnt_q <= o_last ? '0 : cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_bridge.sv
// cmd_bridge: byte-stream command engine driving
// burst memory access and a small register file.
module cmd_bridge
    import cmd_bridge_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int LEN_W    = 14,
    parameter int NUM_REGS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    cmd_bridge_if.slave           bus,
    output logic [8*NUM_REGS-1:0] o_regs,
    output logic                  o_dev_rst,
    output logic                  o_busy
);
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W:0]    rem_q;
    logic [7:0]        out_q;
    logic              rd_first_q;

    logic              h_last;
    logic              h_valid;
    logic [3:0]        h_id;
    logic [ADDR_W-1:0] h_addr;
    logic [LEN_W-1:0]  h_len;

    logic              take_hdr;
    logic              wr_fire;
    logic              last_byte;
    logic              reg_hit;
    logic [7:0]        reg_rd;

    assign take_hdr  = bus.in_valid && bus.in_ready && (state_q == ST_HDR);
    assign wr_fire   = (state_q == ST_WR_DATA) && bus.in_valid;
    assign last_byte = rem_q == (LEN_W+1)'(1);

    assign bus.in_ready  = i_rst_n &&
                           (state_q == ST_HDR || state_q == ST_WR_DATA);
    assign bus.out_valid = (state_q == ST_RD_DATA) || (state_q == ST_RESP);
    assign bus.out_data  = (state_q == ST_RD_DATA && rd_first_q) ?
                           bus.mem_rdata : out_q;
    assign bus.mem_req   = (state_q == ST_RD_ISSUE) || wr_fire;
    assign bus.mem_we    = wr_fire;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wr_fire ? bus.in_data : 8'h00;
    assign o_dev_rst     = state_q == ST_RESET;
    assign o_busy        = state_q != ST_HDR;

    cmd_bridge_hdr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_hdr (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_take      (take_hdr),
        .i_data      (bus.in_data),
        .o_last      (h_last),
        .o_hdr_valid (h_valid),
        .o_id        (h_id),
        .o_addr      (h_addr),
        .o_len       (h_len)
    );

    // Register index range check and read mux.
    always_comb begin
        reg_hit = h_addr < ADDR_W'(NUM_REGS);
        reg_rd  = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (h_addr == ADDR_W'(i)) reg_rd = o_regs[i*8 +: 8];
        end
    end

    // Command FSM: dispatch, burst sequencing and status responses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_HDR;
            addr_q     <= '0;
            rem_q      <= '0;
            out_q      <= 8'h00;
            rd_first_q <= 1'b0;
            o_regs     <= '0;
        end else begin
            unique case (state_q)
                ST_HDR: begin
                    if (h_last) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (h_valid) begin
                        addr_q <= h_addr;
                        rem_q  <= {1'b0, h_len} + (LEN_W+1)'(1);
                        unique case (1'b1)
                            (h_id == CMD_RESET):
                                state_q <= ST_RESET;
                            (h_id == CMD_READ):
                                state_q <= ST_RD_ISSUE;
                            (h_id == CMD_WRITE):
                                state_q <= ST_WR_DATA;
                            (h_id == CMD_REG_READ): begin
                                out_q   <= reg_hit ? reg_rd : STS_BAD_REG;
                                state_q <= ST_RESP;
                            end
                            (h_id == CMD_REG_WRITE): begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (h_addr == ADDR_W'(i))
                                        o_regs[i*8 +: 8] <= 8'(h_len);
                                end
                                out_q   <= reg_hit ? STS_OK : STS_BAD_REG;
                                state_q <= ST_RESP;
                            end
                            default: begin
                                out_q   <= STS_BAD_ID;
                                state_q <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_RESET: begin
                    o_regs  <= '0;
                    out_q   <= STS_OK;
                    state_q <= ST_RESP;
                end
                ST_RD_ISSUE: begin
                    rd_first_q <= 1'b1;
                    state_q    <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rd_first_q) begin
                        out_q      <= bus.mem_rdata;
                        rd_first_q <= 1'b0;
                    end
                    if (bus.out_ready) begin
                        if (last_byte) begin
                            state_q <= ST_HDR;
                        end else begin
                            rem_q   <= rem_q - (LEN_W+1)'(1);
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (bus.in_valid) begin
                        rem_q  <= rem_q - (LEN_W+1)'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                        if (last_byte) begin
                            out_q   <= STS_OK;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.out_ready) state_q <= ST_HDR;
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_bridge.sv
// tb_cmd_bridge: scoreboard bench for cmd_bridge
// with a behavioural byte memory.
module tb_cmd_bridge;
    import cmd_bridge_pkg::*;

    localparam int ADDR_W   = 14;
    localparam int LEN_W    = 14;
    localparam int NUM_REGS = 4;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic [8*NUM_REGS-1:0] o_regs;
    logic                  o_dev_rst;
    logic                  o_busy;

    cmd_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    cmd_bridge #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .bus       (bus),
        .o_regs    (o_regs),
        .o_dev_rst (o_dev_rst),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]        exp_out[$];
    logic [ADDR_W+7:0] exp_wr[$];
    logic [7:0]        mem[int];
    logic [7:0]        ref_mem[int];
    logic [ADDR_W+7:0] e;
    bit                toggle = 1'b0;
    int                dev_cnt = 0;
    bit                prev_stall = 1'b0;
    logic [7:0]        prev_data = 8'h00;

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: read data one cycle after the request.
    always @(posedge i_clk) begin
        if (bus.mem_req && bus.mem_we) begin
            mem[int'(bus.mem_addr)] = bus.mem_wdata;
        end else if (bus.mem_req) begin
            bus.mem_rdata <= mem.exists(int'(bus.mem_addr)) ?
                mem[int'(bus.mem_addr)] : pat(int'(bus.mem_addr));
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("out_hold_valid", 32'(bus.out_valid), 32'(1));
                check("out_hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out.size() == 0)
                    check("extra_out", 32'(1), 32'(0));
                else
                    check("out_data", 32'(bus.out_data),
                          32'(exp_out.pop_front()));
            end
            if (bus.mem_req && bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("extra_wr", 32'(1), 32'(0));
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(e[ADDR_W+7:8]));
                    check("wr_data", 32'(bus.mem_wdata), 32'(e[7:0]));
                end
            end
            if (o_dev_rst) dev_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            bus.out_ready = toggle ? ~bus.out_ready : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge i_clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) check("in_timeout", 32'(1), 32'(0));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [3:0] id, input logic [13:0] addr,
                            input logic [13:0] len, input int gap);
        logic [31:0] h;
        h = {id, addr, len};
        for (int i = 0; i < 4; i++) begin
            send_byte(h[i*8 +: 8]);
            if (i < 3) repeat (gap) tick();
        end
    endtask

    task automatic wr_cmd(input logic [13:0] addr, input logic [13:0] len,
                          input logic [7:0] b0, input int n_send);
        logic [13:0] a;
        logic [7:0]  d;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 14'(i);
            d = b0 + 8'(i);
            if (i < n_send) begin
                exp_wr.push_back({a, d});
                ref_mem[int'(a)] = d;
            end
        end
        if (n_send == int'(len) + 1) exp_out.push_back(STS_OK);
        send_hdr(CMD_WRITE, addr, len, 0);
        for (int i = 0; i < n_send; i++) send_byte(b0 + 8'(i));
    endtask

    task automatic rd_cmd(input logic [13:0] addr, input logic [13:0] len);
        logic [13:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 14'(i);
            exp_out.push_back(ref_mem.exists(int'(a)) ?
                              ref_mem[int'(a)] : pat(int'(a)));
        end
        send_hdr(CMD_READ, addr, len, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_out.size() != 0 || exp_wr.size() != 0 || o_busy)
               && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 32'(1), 32'(0));
        tick();
    endtask

    initial begin
        int n;
        int base;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        i_rst_n      = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'(0));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_data", 32'(bus.out_data), 32'(0));
        check("rst_mem_req", 32'(bus.mem_req), 32'(0));
        check("rst_mem_we", 32'(bus.mem_we), 32'(0));
        check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
        check("rst_regs", 32'(o_regs), 32'(0));
        check("rst_dev_rst", 32'(o_dev_rst), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rdy_after_rst", 32'(bus.in_ready), 32'(1));
        tick();

        wr_cmd(14'h0010, 14'd3, 8'hA0, 4);
        drain();

        rd_cmd(14'h0010, 14'd3);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!bus.out_valid && n < 10);
        check("rd_latency", 32'(n), 32'(3));
        drain();

        toggle = 1'b1;
        rd_cmd(14'h0011, 14'd2);
        drain();
        toggle = 1'b0;
        tick();

        wr_cmd(14'h3FFF, 14'd1, 8'h3C, 2);
        drain();
        rd_cmd(14'h3FFF, 14'd1);
        drain();

        exp_out.push_back(STS_OK);
        send_hdr(CMD_REG_WRITE, 14'd1, 14'h005A, 2);
        drain();
        check("reg1_val", 32'(o_regs[15:8]), 32'h5A);
        check("reg0_val", 32'(o_regs[7:0]), 32'h00);
        exp_out.push_back(8'h5A);
        send_hdr(CMD_REG_READ, 14'd1, 14'd0, 0);
        drain();
        exp_out.push_back(STS_BAD_REG);
        send_hdr(CMD_REG_READ, 14'd7, 14'd0, 1);
        drain();
        exp_out.push_back(STS_BAD_REG);
        send_hdr(CMD_REG_WRITE, 14'd5, 14'h0033, 0);
        drain();
        check("regs_after_bad", 32'(o_regs), 32'h00005A00);

        exp_out.push_back(STS_BAD_ID);
        send_hdr(4'd9, 14'd0, 14'd0, 0);
        drain();

        base = dev_cnt;
        exp_out.push_back(STS_OK);
        send_hdr(CMD_RESET, 14'd0, 14'd0, 0);
        drain();
        check("dev_rst_pulse", 32'(dev_cnt - base), 32'(1));
        check("regs_cleared", 32'(o_regs), 32'(0));

        wr_cmd(14'h0020, 14'd3, 8'hC0, 2);
        i_rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'(0));
        check("abort_busy", 32'(o_busy), 32'(0));
        check("abort_mem_req", 32'(bus.mem_req), 32'(0));
        check("abort_mem_addr", 32'(bus.mem_addr), 32'(0));
        check("abort_out_valid", 32'(bus.out_valid), 32'(0));
        exp_wr.delete();
        exp_out.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        wr_cmd(14'h0020, 14'd0, 8'h77, 1);
        drain();
        rd_cmd(14'h0020, 14'd2);
        drain();

        check("out_left", 32'(exp_out.size()), 32'(0));
        check("wr_left", 32'(exp_wr.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
